// File: rtl/lvl_bkt_ctrl_if.sv
// Control and level-state array port bundle for lvl_bkt_ctrl.
// The slave modport is the sequencer side; the master modport is the surrounding control and array.
interface lvl_bkt_ctrl_if #(
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_BIN_ID     = 10,
    parameter int WIDTH_LVL_STATES = 11,
    parameter int WIDTH_IDX        = 3
);
    logic                        start_i;
    logic                        abort_i;
    logic [WIDTH_LVL-1:0]        max_lvl_i;
    logic                        busy_o;
    logic                        done_o;
    logic                        found_o;
    logic [WIDTH_LVL-1:0]        bkt_lvl_o;
    logic [WIDTH_BIN_ID-1:0]     bkt_bin_o;
    logic [WIDTH_IDX-1:0]        rd_idx_o;
    logic [WIDTH_LVL_STATES-1:0] rd_states_i;
    logic [NUM_LVLS-1:0]         wr_en_o;
    logic [WIDTH_LVL_STATES-1:0] wr_state_o;

    modport master (
        output start_i, abort_i, max_lvl_i, rd_states_i,
        input  busy_o, done_o, found_o, bkt_lvl_o, bkt_bin_o, rd_idx_o, wr_en_o, wr_state_o
    );

    modport slave (
        input  start_i, abort_i, max_lvl_i, rd_states_i,
        output busy_o, done_o, found_o, bkt_lvl_o, bkt_bin_o, rd_idx_o, wr_en_o, wr_state_o
    );
endinterface

// File: rtl/lvl_bkt_ctrl.sv
// Backtrack-level sequencer: scans level states downward from the conflict level, marks the
// first level without has_bkt as backtracked and clears every level above it.
module lvl_bkt_ctrl #(
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_BIN_ID     = 10,
    parameter int WIDTH_LVL_STATES = 11,
    parameter int WIDTH_IDX        = 3
) (
    input  logic          clk,
    input  logic          rst,
    lvl_bkt_ctrl_if.slave bus
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SCAN = 3'd1;
    localparam logic [2:0] ST_MARK = 3'd2;
    localparam logic [2:0] ST_CLR  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [WIDTH_LVL-1:0] LVL_ZERO = {WIDTH_LVL{1'b0}};
    localparam logic [WIDTH_LVL-1:0] LVL_ONE  = WIDTH_LVL'(1);
    localparam logic [WIDTH_LVL-1:0] LVL_MAX  = WIDTH_LVL'(NUM_LVLS);

    logic [2:0]                  state_q, state_d;
    logic [WIDTH_LVL-1:0]        cur_q, cur_d;
    logic                        found_q, found_d;
    logic [WIDTH_LVL-1:0]        bkt_lvl_q, bkt_lvl_d;
    logic [WIDTH_BIN_ID-1:0]     bkt_bin_q, bkt_bin_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [WIDTH_IDX-1:0]        rd_idx_q, rd_idx_d;
    logic [NUM_LVLS-1:0]         wr_en_q, wr_en_d;
    logic [WIDTH_LVL_STATES-1:0] wr_state_q, wr_state_d;
    logic [WIDTH_LVL-1:0]        mlvl_s;

    assign mlvl_s = (bus.max_lvl_i > LVL_MAX) ? LVL_MAX : bus.max_lvl_i;

    // Sequencer next state, scan cursor and search result.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        found_d   = found_q;
        bkt_lvl_d = bkt_lvl_q;
        bkt_bin_d = bkt_bin_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    found_d   = 1'b0;
                    bkt_lvl_d = LVL_ZERO;
                    bkt_bin_d = {WIDTH_BIN_ID{1'b0}};
                    cur_d     = mlvl_s;
                    state_d   = (mlvl_s == LVL_ZERO) ? ST_DONE : ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (bus.abort_i) begin
                    state_d = ST_IDLE;
                end else if (!bus.rd_states_i[0]) begin
                    found_d   = 1'b1;
                    bkt_lvl_d = cur_q;
                    bkt_bin_d = bus.rd_states_i[WIDTH_LVL_STATES-1:1];
                    state_d   = ST_MARK;
                end else if (cur_q == LVL_ONE) begin
                    state_d = ST_DONE;
                end else begin
                    cur_d = cur_q - LVL_ONE;
                end
            end
            ST_MARK: state_d = bus.abort_i ? ST_IDLE : ST_CLR;
            ST_CLR:  state_d = bus.abort_i ? ST_IDLE : ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        rd_idx_d   = {WIDTH_IDX{1'b0}};
        wr_en_d    = {NUM_LVLS{1'b0}};
        wr_state_d = {WIDTH_LVL_STATES{1'b0}};
        case (state_d)
            ST_SCAN: rd_idx_d = WIDTH_IDX'(cur_d - LVL_ONE);
            ST_MARK: begin
                for (int i = 0; i < NUM_LVLS; i++) begin
                    wr_en_d[i] = (WIDTH_LVL'(i) == (bkt_lvl_d - LVL_ONE));
                end
                wr_state_d = {bkt_bin_d, 1'b1};
            end
            ST_CLR: begin
                for (int i = 0; i < NUM_LVLS; i++) begin
                    wr_en_d[i] = (WIDTH_LVL'(i) >= bkt_lvl_d);
                end
            end
            default: rd_idx_d = {WIDTH_IDX{1'b0}};
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_q      <= LVL_ZERO;
            found_q    <= 1'b0;
            bkt_lvl_q  <= LVL_ZERO;
            bkt_bin_q  <= {WIDTH_BIN_ID{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_idx_q   <= {WIDTH_IDX{1'b0}};
            wr_en_q    <= {NUM_LVLS{1'b0}};
            wr_state_q <= {WIDTH_LVL_STATES{1'b0}};
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            found_q    <= found_d;
            bkt_lvl_q  <= bkt_lvl_d;
            bkt_bin_q  <= bkt_bin_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_idx_q   <= rd_idx_d;
            wr_en_q    <= wr_en_d;
            wr_state_q <= wr_state_d;
        end
    end

    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.found_o    = found_q;
    assign bus.bkt_lvl_o  = bkt_lvl_q;
    assign bus.bkt_bin_o  = bkt_bin_q;
    assign bus.rd_idx_o   = rd_idx_q;
    assign bus.wr_state_o = wr_state_q;
    // An abort or reset sampled this cycle must suppress the write that would land on the same edge.
    assign bus.wr_en_o    = (rst || bus.abort_i) ? {NUM_LVLS{1'b0}} : wr_en_q;
endmodule

// File: doc/lvl_bkt_ctrl.md
# lvl_bkt_ctrl

Sequencer for the Sat Engine level-state array. On a conflict it walks the per-level states downward from the conflict level and finds the highest level whose `has_bkt` flag is clear. It reports that level and its decision bin, marks the level as backtracked, and clears every level above it. It sits between the conflict-analysis control and the level-state array's read/write ports.

## Interface
Parameters:
- NUM_LVLS, 8: number of level entries; level L (1..NUM_LVLS) is stored at index L-1, and level 0 has no entry.
- WIDTH_LVL, 16: level number width.
- WIDTH_BIN_ID, 10: bin id width.
- WIDTH_LVL_STATES, 11: entry width, always WIDTH_BIN_ID+1. Bit 0 is `has_bkt`; bits [WIDTH_LVL_STATES-1:1] are `dcd_bin`.
- WIDTH_IDX, 3: ceil(log2 NUM_LVLS).

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  begin a search; accepted only in IDLE.
- abort_i  in  1  cancel an in-progress search.
- max_lvl_i  in  WIDTH_LVL  conflict level; sampled when start is accepted.
- busy_o  out  1  high whenever state != IDLE.
- done_o  out  1  one-cycle pulse in DONE.
- found_o  out  1  a backtrack level exists; 0 means the conflict is at root (UNSAT).
- bkt_lvl_o  out  WIDTH_LVL  backtrack level found.
- bkt_bin_o  out  WIDTH_BIN_ID  `dcd_bin` of the backtrack level.
- rd_idx_o  out  WIDTH_IDX  array read index.
- rd_states_i  in  WIDTH_LVL_STATES  entry at rd_idx_o, combinational (same-cycle) read.
- wr_en_o  out  NUM_LVLS  per-entry write enables.
- wr_state_o  out  WIDTH_LVL_STATES  value written to every enabled entry.

## Operation
- States: IDLE, SCAN, MARK, CLR, DONE. Registers: `cur` (current level), `mlvl` (clamped max level), plus the output registers.
- IDLE, start_i=1:
  - Clear found_o, bkt_lvl_o and bkt_bin_o.
  - mlvl = min(max_lvl_i, NUM_LVLS); cur = mlvl.
  - If mlvl==0, go to DONE; otherwise go to SCAN.
- SCAN: rd_idx_o = cur-1.
  - If rd_states_i[0]==0: found_o=1, bkt_lvl_o=cur, bkt_bin_o=rd_states_i[WIDTH_LVL_STATES-1:1], go to MARK.
  - Else if cur==1: found_o stays 0, go to DONE with no writes.
  - Else: cur=cur-1.
- MARK: wr_en_o has only bit bkt_lvl_o-1 set; wr_state_o = {bkt_bin_o, 1'b1}. Go to CLR.
- CLR: wr_en_o[i]=1 for all i >= bkt_lvl_o (indices bkt_lvl_o..NUM_LVLS-1); wr_state_o = 0. Go to DONE. If bkt_lvl_o==NUM_LVLS, wr_en_o is all zero.
- DONE: done_o=1, then go to IDLE. found_o, bkt_lvl_o and bkt_bin_o hold until the next accepted start.
- start_i outside IDLE is ignored.
- abort_i in SCAN, MARK or CLR: go to IDLE next cycle. No done_o pulse, and no write in the cycle abort_i is sampled high. abort_i wins over start_i. In IDLE and DONE, abort_i has no effect.
- wr_en_o is 0 in every state except MARK and CLR. rd_idx_o is 0 outside SCAN.

## Timing
- Reset: state=IDLE. busy_o, done_o, found_o, bkt_lvl_o, bkt_bin_o, rd_idx_o, wr_en_o and wr_state_o are all 0.
- rst has priority over every input. Reset mid-search discards the search, and no write occurs in the rst cycle.
- Start accepted at edge t0 (end of cycle t0). SCAN occupies t0+1 .. t0+k, where k = mlvl - bkt_lvl + 1.
- Found path: MARK at t0+k+1, CLR at t0+k+2, done_o at t0+k+3.
- Not-found path: done_o at t0+mlvl+1.
- mlvl==0: done_o at t0+1.
- Back-to-back: the earliest next start is accepted in the IDLE cycle after DONE.
- The array must present rd_states_i in the same cycle as rd_idx_o. No read-after-write hazard exists, because no reads occur after MARK.

## Test plan
- Reset: hold rst 2 cycles with start_i=1 -> all outputs 0, busy_o=0, and no wr_en_o activity.
- Found: max_lvl_i=5; levels 5 and 4 have has_bkt=1; level 3 = {0x2A5, 0}.
  - done_o at t0+6 with found_o=1, bkt_lvl_o=3, bkt_bin_o=0x2A5.
  - MARK: wr_en_o=8'b0000_0100, wr_state_o=0x54B.
  - CLR: wr_en_o=8'b1111_1000, wr_state_o=0.
- Not found: max_lvl_i=4 with levels 1-4 all has_bkt=1 -> done_o at t0+5, found_o=0, wr_en_o=0 throughout.
- Edges:
  - max_lvl_i=0 -> done_o at t0+1, found_o=0.
  - max_lvl_i=12 -> first rd_idx_o=7.
  - Level 8 has has_bkt=0 with max_lvl_i=8 -> CLR wr_en_o=0.
- Abort/reset: abort_i in the 2nd SCAN cycle -> IDLE next cycle, no done_o, no writes. Repeat with rst instead of abort_i -> same result, and outputs are zeroed.
- start_i pulsed during SCAN -> ignored; exactly one done_o, and results are unchanged.
